prism_cfg_loader: RTL and testbench
===================================

// Module: prism_cfg_loader
// PURPOSE
//  Write-side controller for the PRISM latch config array. Assembles WIDTH-bit config words
//  from 32-bit host writes, then shifts each word into the latch chain by strobing the per-stage
//  latch enables from the last stage down to stage 0. It drives the array's data_in and latch_en.
//  Enables are registered, one-hot and non-overlapping, so every latch samples a stable upstream value.
// PARAMETERS
//  WIDTH    48  config word width; legal range 33..64
//  DEPTH    8   number of latch stages in the array; power of 2, >= 2
//  PULSE_W  2   cycles each latch_en bit stays high (>= 1)
//  GAP_W    1   all-zero cycles between successive enables (>= 1)
// PORTS
//  clk         in   1                 system clock
//  rst_n       in   1                 async active-low reset
//  wr_data     in   32                host write data
//  wr_lo       in   1                 1-cycle strobe: staging[31:0] <= wr_data
//  wr_hi       in   1                 1-cycle strobe: staging[WIDTH-1:32] <= wr_data[WIDTH-33:0]; commit
//  ovf_clr     in   1                 clears the ovf flag
//  cfg_data    out  WIDTH             to array data_in; held word being shifted
//  latch_en    out  DEPTH             to array latch_en; registered, at most one bit high
//  busy        out  1                 shift sequence in progress; engine must be halted
//  load_cnt    out  $clog2(DEPTH)     words committed, modulo DEPTH
//  ovf         out  1                 sticky: wr_hi was dropped because busy was high
// BEHAVIOUR
//  Reset (async): cfg_data=0, latch_en=0, busy=0, load_cnt=0, ovf=0, staging=0, state IDLE.
//   - The array is transparent during reset and must see cfg_data=0.
//   - Reset mid-sequence aborts at once: latch_en drops to 0 asynchronously, no partial resume.
//  Staging:
//   - wr_lo and wr_hi are accepted in any state.
//   - wr_hi commits only in IDLE.
//   - If wr_lo and wr_hi arrive in the same cycle, the committed word uses the new wr_lo data (bypass).
//  States:
//   - IDLE: busy=0, latch_en=0. On wr_hi: cfg_data <= {new hi, lo}, idx <= DEPTH-1, go to PULSE.
//   - PULSE: latch_en = 1<<idx for PULSE_W cycles, then go to GAP.
//   - GAP: latch_en = 0 for GAP_W cycles.
//     - If idx != 0: idx <= idx-1, go to PULSE.
//     - If idx == 0: load_cnt <= load_cnt+1 (wraps DEPTH-1 -> 0), go to IDLE.
//  Timing:
//   - wr_hi sampled at edge N gives busy=1 and latch_en[DEPTH-1]=1 from cycle N+1.
//   - The sequence lasts DEPTH*(PULSE_W+GAP_W) cycles; busy drops in the cycle after the last gap.
//  Invariants:
//   - cfg_data is stable from commit until return to IDLE. Staging writes during busy never reach cfg_data.
//   - latch_en is a direct flop output and is never glitched by wr_* inputs.
//   - In stage order, new word -> stage 0 and old stage i -> stage i+1; the old stage DEPTH-1 is discarded.
//  Overflow:
//   - wr_hi while busy: the commit is dropped, staging hi is still updated, ovf <= 1.
//   - ovf_clr clears ovf. If ovf_clr and a new overflow occur in the same cycle, set wins.
//   - ovf does not block later commits.
//  Width: hi field is WIDTH-32 bits, taken from wr_data LSBs; unused wr_data upper bits are ignored.
// STRUCTURE
//  Shared package prism_pkg:
//   - state enum {IDLE, PULSE, GAP}
//   - default WIDTH/DEPTH constants shared with the latch array and the PRISM engine.
//  One sub-module, prism_cfg_strobe_seq: owns the state, phase counter, idx, latch_en flops and done pulse.
//  The top level owns staging, cfg_data, load_cnt and ovf.
// TESTING (bench includes a behavioural model of the latch chain; defaults WIDTH=48, DEPTH=8)
//  1. wr_lo=0x89ABCDEF then wr_hi=0x4567 -> busy for 24 cycles; latch_en walks 0x80,0x40..0x01,
//     each high 2 cycles with 1 zero cycle between; model stage0=0x4567_89ABCDEF; load_cnt=1.
//  2. Eight commits of words k=1..8 -> model stage i = word 8-i; load_cnt wraps to 0; ovf=0.
//  3. wr_hi during busy -> sequence completes unchanged, shifts the original word, ovf=1.
//     Then ovf_clr -> ovf=0. Then wr_hi -> new sequence starts.
//  4. wr_lo=0x11111111 and wr_hi=0x2222 in the same IDLE cycle -> cfg_data=0x2222_11111111 next cycle.
//  5. rst_n low while latch_en=0x10 -> latch_en=0, busy=0, cfg_data=0 with no clock edge;
//     after release, IDLE and load_cnt=0.
//  6. Every cycle, check $onehot0(latch_en); check cfg_data unchanged while busy=1.

Source files
------------

// File: rtl/prism_pkg.sv
// Shared PRISM definitions: default array geometry and the config-loader state encoding.
package prism_pkg;

  localparam int unsigned PrismWidth = 48;
  localparam int unsigned PrismDepth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StGap
  } cfg_state_e;

endpackage

// File: rtl/prism_cfg_strobe_seq.sv
// Latch-enable sequencer: walks a registered one-hot enable from stage DEPTH-1 down to stage 0,
// each pulse PULSE_W cycles wide and separated by GAP_W all-zero cycles.
module prism_cfg_strobe_seq
  import prism_pkg::*;
#(
  parameter int unsigned DEPTH   = PrismDepth,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [DEPTH-1:0] latch_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned PhaseMax = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned PhaseW   = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;

  localparam logic [PhaseW-1:0] PulseLast = PhaseW'(PULSE_W - 1);
  localparam logic [PhaseW-1:0] GapLast   = PhaseW'(GAP_W - 1);
  localparam logic [IdxW-1:0]   IdxTop    = IdxW'(DEPTH - 1);

  cfg_state_e        state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DEPTH-1:0]  latch_en_q, latch_en_d;

  // The enable for the next cycle is decided here and flopped, so latch_en never sees comb logic.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    latch_en_d = latch_en_q;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        latch_en_d = '0;
        if (start) begin
          state_d            = StPulse;
          phase_d            = '0;
          idx_d              = IdxTop;
          latch_en_d[IdxTop] = 1'b1;
        end
      end
      StPulse: begin
        if (phase_q == PulseLast) begin
          state_d    = StGap;
          phase_d    = '0;
          latch_en_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StGap: begin
        if (phase_q == GapLast) begin
          phase_d = '0;
          if (idx_q != '0) begin
            state_d           = StPulse;
            idx_d             = idx_q - 1'b1;
            latch_en_d[idx_d] = 1'b1;
          end else begin
            state_d = StIdle;
            done    = 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d    = StIdle;
        latch_en_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      idx_q      <= '0;
      latch_en_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      latch_en_q <= latch_en_d;
    end
  end

  assign latch_en = latch_en_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: rtl/prism_cfg_loader.sv
// PRISM latch-array config loader: stages a WIDTH-bit word from two host writes, holds it on
// cfg_data and shifts it into the latch chain via prism_cfg_strobe_seq.
module prism_cfg_loader
  import prism_pkg::*;
#(
  parameter int unsigned WIDTH   = PrismWidth,
  parameter int unsigned DEPTH   = PrismDepth,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              wr_data,
  input  logic                     wr_lo,
  input  logic                     wr_hi,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         cfg_data,
  output logic [DEPTH-1:0]         latch_en,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] load_cnt,
  output logic                     ovf
);

  localparam int unsigned HiW  = WIDTH - 32;
  localparam int unsigned CntW = $clog2(DEPTH);

  logic [WIDTH-1:0] staging_q, staging_d;
  logic [WIDTH-1:0] cfg_data_q, cfg_data_d;
  logic [CntW-1:0]  load_cnt_q, load_cnt_d;
  logic             ovf_q, ovf_d;
  logic             commit, drop, seq_done;

  prism_cfg_strobe_seq #(
    .DEPTH  (DEPTH),
    .PULSE_W(PULSE_W),
    .GAP_W  (GAP_W)
  ) u_strobe_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (commit),
    .latch_en(latch_en),
    .busy    (busy),
    .done    (seq_done)
  );

  assign commit = wr_hi & ~busy;
  assign drop   = wr_hi & busy;

  // staging_d already carries a same-cycle wr_lo, so a combined lo/hi write commits the new lo.
  always_comb begin
    staging_d  = staging_q;
    cfg_data_d = cfg_data_q;
    load_cnt_d = load_cnt_q;
    ovf_d      = ovf_q;
    if (wr_lo) staging_d[31:0] = wr_data;
    if (wr_hi) staging_d[WIDTH-1:32] = wr_data[HiW-1:0];
    if (commit) cfg_data_d = staging_d;
    if (seq_done) load_cnt_d = load_cnt_q + 1'b1;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q  <= '0;
      cfg_data_q <= '0;
      load_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      staging_q  <= staging_d;
      cfg_data_q <= cfg_data_d;
      load_cnt_q <= load_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  generate
    if (WIDTH < 64) begin : g_unused_hi
      logic unused_wr_data_hi;
      assign unused_wr_data_hi = ^wr_data[31:HiW];
    end
  endgenerate

  assign cfg_data = cfg_data_q;
  assign load_cnt = load_cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_prism_cfg_loader.sv
// Self-checking bench for prism_cfg_loader: schedule-based model of the enable walk, a model of
// the latch chain driven by the DUT outputs, directed scenarios and a randomized soak.
module tb_prism_cfg_loader;

  localparam int WIDTH   = 48;
  localparam int DEPTH   = 8;
  localparam int PULSE_W = 2;
  localparam int GAP_W   = 1;
  localparam int PER     = PULSE_W + GAP_W;
  localparam int SEQ     = DEPTH * PER;
  localparam int CNTW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      wr_data = '0;
  logic             wr_lo = 1'b0;
  logic             wr_hi = 1'b0;
  logic             ovf_clr = 1'b0;
  logic [WIDTH-1:0] cfg_data;
  logic [DEPTH-1:0] latch_en;
  logic             busy;
  logic [CNTW-1:0]  load_cnt;
  logic             ovf;

  int checks = 0;
  int failures = 0;

  // Reference state: what the outputs must be in the current cycle.
  logic [WIDTH-1:0] m_stage, m_cfg;
  int               m_seq;
  int               m_load;
  logic             m_ovf;
  logic [WIDTH-1:0] exp_chain[DEPTH];
  logic [WIDTH-1:0] chain[DEPTH];
  logic [WIDTH-1:0] prev_cfg;
  logic             prev_busy;

  prism_cfg_loader #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .PULSE_W(PULSE_W),
    .GAP_W  (GAP_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .wr_lo   (wr_lo),
    .wr_hi   (wr_hi),
    .ovf_clr (ovf_clr),
    .cfg_data(cfg_data),
    .latch_en(latch_en),
    .busy    (busy),
    .load_cnt(load_cnt),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the array plus the loader's expected behaviour, evaluated mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_stage = '0;
        m_cfg = '0;
        m_seq = 0;
        m_load = 0;
        m_ovf = 1'b0;
        prev_busy = 1'b0;
        prev_cfg = '0;
        for (int i = 0; i < DEPTH; i++) begin
          exp_chain[i] = '0;
          chain[i] = '0;
        end
      end else begin
        logic [DEPTH-1:0] e;
        logic [WIDTH-1:0] st;
        int               k;
        int               old;
        e = '0;
        if (m_seq > 0) begin
          k = SEQ - m_seq;
          if ((k % PER) < PULSE_W) e[DEPTH-1-(k/PER)] = 1'b1;
        end
        chk("latch_en", 64'(latch_en), 64'(e));
        chk("busy", 64'(busy), 64'(m_seq > 0));
        chk("cfg_data", 64'(cfg_data), 64'(m_cfg));
        chk("load_cnt", 64'(load_cnt), 64'(m_load));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("onehot0", 64'($onehot0(latch_en)), 64'd1);
        if (busy && prev_busy) chk("cfg_stable", 64'(cfg_data), 64'(prev_cfg));
        prev_busy = busy;
        prev_cfg = cfg_data;

        // Latch chain: an enabled stage copies its upstream neighbour.
        for (int i = 0; i < DEPTH; i++) begin
          if (latch_en[i]) chain[i] = (i == 0) ? cfg_data : chain[i-1];
        end
        if (m_seq == 0) begin
          for (int i = 0; i < DEPTH; i++) chk($sformatf("chain[%0d]", i), 64'(chain[i]),
                                               64'(exp_chain[i]));
        end

        // Advance to the state after the coming rising edge.
        old = m_seq;
        st = m_stage;
        if (wr_lo) st[31:0] = wr_data;
        if (wr_hi) st[WIDTH-1:32] = wr_data[WIDTH-33:0];
        m_stage = st;
        if (m_seq > 0) begin
          m_seq--;
          if (m_seq == 0) m_load = (m_load + 1) % DEPTH;
        end
        if (wr_hi && old == 0) begin
          m_cfg = st;
          m_seq = SEQ;
          for (int i = DEPTH - 1; i > 0; i--) exp_chain[i] = exp_chain[i-1];
          exp_chain[0] = st;
        end
        if (wr_hi && old > 0) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic lo, input logic hi, input logic [31:0] d, input logic clr);
    wr_lo = lo;
    wr_hi = hi;
    wr_data = d;
    ovf_clr = clr;
    cyc(1);
    wr_lo = 1'b0;
    wr_hi = 1'b0;
    ovf_clr = 1'b0;
    wr_data = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      cyc(1);
      n++;
    end
    chk("idle_within_bound", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    int n;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("reset_cfg", 64'(cfg_data), 64'd0);
    chk("reset_load_cnt", 64'(load_cnt), 64'd0);

    // 1: single word, timing and shift into stage 0
    wr(1'b1, 1'b0, 32'h89AB_CDEF, 1'b0);
    wr(1'b0, 1'b1, 32'h0000_4567, 1'b0);
    chk("t1_first_en", 64'(latch_en), 64'h80);
    n = 0;
    while (busy && n < 100) begin
      cyc(1);
      n++;
    end
    chk("t1_busy_cycles", 64'(n), 64'd24);
    chk("t1_stage0", 64'(chain[0]), 64'h4567_89AB_CDEF);
    chk("t1_stage1", 64'(chain[1]), 64'd0);
    chk("t1_load_cnt", 64'(load_cnt), 64'd1);

    // 2: eight words fill the chain, counter wraps
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      wr(1'b1, 1'b0, 32'hA500_0000 + 32'(k), 1'b0);
      wr(1'b0, 1'b1, 32'(k), 1'b0);
      wait_idle();
    end
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_stage", 64'(chain[i]), {16'd0, 16'(8 - i), 32'hA500_0000 + 32'(8 - i)});
    end
    chk("t2_load_cnt", 64'(load_cnt), 64'd0);
    chk("t2_ovf", 64'(ovf), 64'd0);

    // 3: overflow, set-wins, clear, later commit still works
    wr(1'b1, 1'b0, 32'hCAFE_F00D, 1'b0);
    wr(1'b0, 1'b1, 32'h0000_1234, 1'b0);
    cyc(3);
    wr(1'b1, 1'b1, 32'h0000_7777, 1'b0);
    chk("t3_ovf_set", 64'(ovf), 64'd1);
    cyc(2);
    wr(1'b0, 1'b1, 32'h0000_5555, 1'b1);
    chk("t3_set_wins", 64'(ovf), 64'd1);
    wait_idle();
    chk("t3_stage0", 64'(chain[0]), 64'h1234_CAFE_F00D);
    wr(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t3_ovf_clr", 64'(ovf), 64'd0);
    wr(1'b0, 1'b1, 32'h0000_9999, 1'b0);
    chk("t3_restart", 64'(busy), 64'd1);
    chk("t3_cfg", 64'(cfg_data), 64'h9999_0000_7777);
    wait_idle();

    // 4: same-cycle lo/hi uses the new lo
    wr(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    wr(1'b1, 1'b1, 32'h1111_2222, 1'b0);
    chk("t4_bypass", 64'(cfg_data), 64'h2222_1111_2222);
    wait_idle();

    // 5: asynchronous reset mid-sequence
    wr(1'b1, 1'b0, 32'h0BAD_F00D, 1'b0);
    wr(1'b0, 1'b1, 32'h0000_00AA, 1'b0);
    n = 0;
    while (latch_en != 8'h10 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("t5_saw_0x10", 64'(latch_en), 64'h10);
    rst_n = 1'b0;
    #1;
    chk("t5_async_en", 64'(latch_en), 64'd0);
    chk("t5_async_busy", 64'(busy), 64'd0);
    chk("t5_async_cfg", 64'(cfg_data), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("t5_post_busy", 64'(busy), 64'd0);
    chk("t5_post_load", 64'(load_cnt), 64'd0);

    // Randomized soak
    repeat (600) begin
      wr_lo = ($urandom_range(0, 3) == 0);
      wr_hi = ($urandom_range(0, 9) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      wr_data = $urandom;
      cyc(1);
    end
    wr_lo = 1'b0;
    wr_hi = 1'b0;
    ovf_clr = 1'b0;
    wait_idle();
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
